pp_pipeline_accel_scan_ctrl: RTL and testbench

PP_PIPELINE_ACCEL_SCAN_CTRL -- requirements
Module: pp_pipeline_accel_scan_ctrl

---
 rtl/pp_pipeline_accel_scan_ctrl.sv | 119 +++++++++++
 tb/tb_pp_pipeline_accel_scan_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pp_pipeline_accel_scan_ctrl.sv
// Frame coordinate scan controller: fetches half-resolution extents from a
// dimension producer, then emits one (row, col) beat per handshake.
module pp_pipeline_accel_scan_ctrl #(
  parameter int unsigned DIM_W = 11,
  parameter int unsigned CNT_W = 22
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             ap_start,
  input  logic             ap_continue,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  output logic             dims_start,
  input  logic             dims_done,
  output logic             dims_continue,
  input  logic [DIM_W-1:0] dims_height_half,
  input  logic [DIM_W-1:0] dims_width_half,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic [DIM_W-1:0] out_row,
  output logic [DIM_W-1:0] out_col,
  output logic             out_tuser,
  output logic             out_tlast,
  output logic [CNT_W-1:0] frame_beats,
  output logic             dims_err
);

  typedef enum logic [1:0] {IDLE, REQ, SCAN, DONE} state_t;

  state_t           state, state_n;
  logic [DIM_W-1:0] h_q, w_q, row_q, col_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ap_ready_q, dims_continue_q, dims_err_q;
  logic [CNT_W-1:0] frame_beats_q;
  logic             beat, col_last, row_last, dims_zero;

  assign beat      = (state == SCAN) && out_tready;
  assign col_last  = (col_q == w_q - DIM_W'(1));
  assign row_last  = (row_q == h_q - DIM_W'(1));
  assign dims_zero = (dims_height_half == '0) || (dims_width_half == '0);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (ap_start)  state_n = REQ;
      REQ:  if (dims_done) state_n = dims_zero ? DONE : SCAN;
      SCAN: if (beat && col_last && row_last) state_n = DONE;
      DONE: if (ap_continue) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake-facing outputs decode straight from registered state so an
  // asynchronous reset removes them without waiting for a clock edge.
  always_comb begin
    ap_idle       = (state == IDLE) && (!ap_start || ap_rst);
    dims_start    = (state == REQ);
    out_tvalid    = (state == SCAN);
    ap_done       = (state == DONE);
    out_tuser     = (state == SCAN) && (row_q == '0) && (col_q == '0);
    out_tlast     = (state == SCAN) && col_last;
    out_row       = row_q;
    out_col       = col_q;
    ap_ready      = ap_ready_q;
    dims_continue = dims_continue_q;
    frame_beats   = frame_beats_q;
    dims_err      = dims_err_q;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      h_q             <= '0;
      w_q             <= '0;
      row_q           <= '0;
      col_q           <= '0;
      cnt_q           <= '0;
      ap_ready_q      <= 1'b0;
      dims_continue_q <= 1'b0;
      dims_err_q      <= 1'b0;
      frame_beats_q   <= '0;
    end else begin
      ap_ready_q      <= (state == IDLE) && ap_start;
      dims_continue_q <= (state == REQ) && dims_done;
      unique case (state)
        IDLE: if (ap_start) cnt_q <= '0;
        REQ: if (dims_done) begin
          h_q        <= dims_height_half;
          w_q        <= dims_width_half;
          row_q      <= '0;
          col_q      <= '0;
          dims_err_q <= dims_zero;
          if (dims_zero) frame_beats_q <= '0;
        end
        SCAN: if (beat) begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (col_last) begin
            col_q <= '0;
            if (row_last) begin
              row_q         <= '0;
              frame_beats_q <= cnt_q + CNT_W'(1);
            end else begin
              row_q <= row_q + DIM_W'(1);
            end
          end else begin
            col_q <= col_q + DIM_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_pipeline_accel_scan_ctrl.sv
// Self-checking bench: expected beat streams are generated per frame from the
// row-major scan rule and compared against the DUT under varied back-pressure.
module tb_pp_pipeline_accel_scan_ctrl;

  localparam int DIM_W = 11;
  localparam int CNT_W = 22;

  logic             ap_clk, ap_rst, ap_start, ap_continue;
  logic             ap_done, ap_idle, ap_ready;
  logic             dims_start, dims_done, dims_continue;
  logic [DIM_W-1:0] dims_height_half, dims_width_half;
  logic             out_tvalid, out_tready, out_tuser, out_tlast;
  logic [DIM_W-1:0] out_row, out_col;
  logic [CNT_W-1:0] frame_beats;
  logic             dims_err;

  int checks = 0;
  int errors = 0;

  typedef struct {int r; int c; bit u; bit l;} beat_t;

  pp_pipeline_accel_scan_ctrl #(.DIM_W(DIM_W), .CNT_W(CNT_W)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_continue(ap_continue), .ap_done(ap_done), .ap_idle(ap_idle),
    .ap_ready(ap_ready), .dims_start(dims_start), .dims_done(dims_done),
    .dims_continue(dims_continue), .dims_height_half(dims_height_half),
    .dims_width_half(dims_width_half), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .out_row(out_row), .out_col(out_col),
    .out_tuser(out_tuser), .out_tlast(out_tlast),
    .frame_beats(frame_beats), .dims_err(dims_err)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before 400000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic randomize_dims();
    dims_height_half = DIM_W'($urandom_range(0, 2047));
    dims_width_half  = DIM_W'($urandom_range(0, 2047));
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_tvalid"}, 32'(out_tvalid), 32'd0);
    check({tag, "_dims_start"}, 32'(dims_start), 32'd0);
    check({tag, "_dims_cont"}, 32'(dims_continue), 32'd0);
    check({tag, "_ap_done"}, 32'(ap_done), 32'd0);
    check({tag, "_ap_ready"}, 32'(ap_ready), 32'd0);
    check({tag, "_frame_beats"}, 32'(frame_beats), 32'd0);
    check({tag, "_dims_err"}, 32'(dims_err), 32'd0);
    check({tag, "_row"}, 32'(out_row), 32'd0);
    check({tag, "_col"}, 32'(out_col), 32'd0);
    check({tag, "_tuser"}, 32'(out_tuser), 32'd0);
    check({tag, "_tlast"}, 32'(out_tlast), 32'd0);
    check({tag, "_idle"}, 32'(ap_idle), 32'd1);
  endtask

  // Starts a frame and answers the producer on the delay-th request cycle.
  task automatic start_req(int h, int w, int delay);
    check("idle_before", 32'(ap_idle), 32'd1);
    ap_start = 1'b1;
    #1;
    check("idle_on_start", 32'(ap_idle), 32'd0);
    tick();
    ap_start = 1'b0;
    for (int i = 1; i <= delay; i++) begin
      check("ap_ready_pulse", 32'(ap_ready), 32'(i == 1));
      check("dims_start_held", 32'(dims_start), 32'd1);
      check("dims_cont_in_req", 32'(dims_continue), 32'd0);
      check("tvalid_in_req", 32'(out_tvalid), 32'd0);
      dims_done = (i == delay);
      if (i == delay) begin
        dims_height_half = DIM_W'(h);
        dims_width_half  = DIM_W'(w);
      end else begin
        randomize_dims();
      end
      tick();
    end
    dims_done = 1'b0;
    randomize_dims();
    check("dims_start_off", 32'(dims_start), 32'd0);
    check("dims_cont_pulse", 32'(dims_continue), 32'd1);
    check("ap_ready_off", 32'(ap_ready), 32'd0);
  endtask

  // mode 0: always ready, 1: toggle every cycle, 2: random. abort_at>0 stops
  // while beat abort_at is being presented.
  task automatic scan(int h, int w, int mode, int abort_at);
    beat_t q[$];
    int    n = 0;
    int    cyc = 0;
    bit    tog = 1'b1;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        q.push_back('{r, c, (r == 0 && c == 0), (c == w - 1)});
    while (q.size() != 0 && cyc < 8 * h * w + 20) begin
      case (mode)
        0:       out_tready = 1'b1;
        1:       begin out_tready = tog; tog = !tog; end
        default: out_tready = 1'($urandom_range(0, 1));
      endcase
      randomize_dims();
      if (cyc > 0) check("dims_cont_once", 32'(dims_continue), 32'd0);
      check("tvalid", 32'(out_tvalid), 32'd1);
      check("row", 32'(out_row), 32'(q[0].r));
      check("col", 32'(out_col), 32'(q[0].c));
      check("tuser", 32'(out_tuser), 32'(q[0].u));
      check("tlast", 32'(out_tlast), 32'(q[0].l));
      if (abort_at > 0 && n == abort_at - 1) return;
      if (out_tready) begin
        void'(q.pop_front());
        n++;
      end
      tick();
      cyc++;
    end
    out_tready = 1'b0;
    check("beats_left", 32'(q.size()), 32'd0);
    check("tvalid_after", 32'(out_tvalid), 32'd0);
  endtask

  task automatic finish_frame(int h, int w);
    check("ap_done", 32'(ap_done), 32'd1);
    check("frame_beats", 32'(frame_beats), 32'(h * w));
    check("dims_err", 32'(dims_err), 32'(h == 0 || w == 0));
    ap_start = 1'b1;
    repeat (3) begin
      tick();
      check("done_held", 32'(ap_done), 32'd1);
      check("ready_in_done", 32'(ap_ready), 32'd0);
      check("dims_start_done", 32'(dims_start), 32'd0);
      check("dims_cont_done", 32'(dims_continue), 32'd0);
      check("tvalid_done", 32'(out_tvalid), 32'd0);
    end
    ap_start    = 1'b0;
    ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;
    check("done_cleared", 32'(ap_done), 32'd0);
    check("idle_after", 32'(ap_idle), 32'd1);
  endtask

  task automatic frame(int h, int w, int mode, int delay);
    start_req(h, w, delay);
    scan(h, w, mode, 0);
    finish_frame(h, w);
  endtask

  initial begin
    ap_rst = 1'b1; ap_start = 1'b0; ap_continue = 1'b0;
    dims_done = 1'b0; out_tready = 1'b0;
    dims_height_half = '0; dims_width_half = '0;
    #12;
    check_reset_outputs("por");
    ap_start = 1'b1;
    #1;
    check("idle_in_rst_start", 32'(ap_idle), 32'd1);
    ap_start = 1'b0;
    tick();
    #2 ap_rst = 1'b0;
    tick();

    frame(2, 3, 0, 1);
    frame(1, 1, 0, 1);
    frame(2, 2, 1, 1);
    frame(3, 2, 0, 5);
    frame(3, 0, 0, 2);
    frame(0, 4, 2, 1);
    frame(1, 7, 2, 3);
    frame(7, 1, 1, 1);

    // Reset while beat 3 of a 4x4 frame is on the bus.
    start_req(4, 4, 2);
    scan(4, 4, 0, 3);
    check("pre_rst_col", 32'(out_col), 32'd2);
    ap_rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) begin
      tick();
      check("tvalid_in_rst", 32'(out_tvalid), 32'd0);
    end
    #2 ap_rst = 1'b0;
    #1;
    check("idle_post_rst", 32'(ap_idle), 32'd1);
    check("tvalid_post_rst", 32'(out_tvalid), 32'd0);
    tick();
    check("no_beat_post_rst", 32'(out_tvalid), 32'd0);
    frame(4, 4, 2, 3);

    for (int k = 0; k < 8; k++)
      frame($urandom_range(0, 5), $urandom_range(0, 5), 2, $urandom_range(1, 4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
